karatsuba_sched: RTL and testbench
==================================

KARATSUBA_SCHED -- requirements
Module: karatsuba_sched

Interface
REQ-001 SHALL have parameter DATA_W, default 32, operand width; even values >= 4 only.
REQ-002 SHALL have parameter CNT_W, default 16, width of the completed-operation counter.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-005 SHALL have port in_valid, input, 1, operand pair A/B is valid.
REQ-006 SHALL have port in_ready, output, 1, block accepts an operand pair.
REQ-007 SHALL have port A, input, DATA_W, unsigned multiplicand.
REQ-008 SHALL have port B, input, DATA_W, unsigned multiplier.
REQ-009 SHALL have port mul_a, output, DATA_W/2+1, operand A of the external shared multiplier.
REQ-010 SHALL have port mul_b, output, DATA_W/2+1, operand B of the external shared multiplier.
REQ-011 SHALL have port mul_p, input, DATA_W+2, combinational product mul_a*mul_b, valid in the same cycle.
REQ-012 SHALL have port out_valid, output, 1, S holds a finished product.
REQ-013 SHALL have port out_ready, input, 1, consumer accepts S.
REQ-014 SHALL have port S, output, 2*DATA_W, unsigned product A*B.
REQ-015 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-016 SHALL have port op_count, output, CNT_W, number of completed output handshakes.

Function
REQ-017 SHALL implement states IDLE, P_HH, P_LL, P_MID, COMB, DONE.
REQ-018 SHALL drive in_ready=1 only in IDLE; an input handshake is in_valid&&in_ready.
REQ-019 SHALL, on input handshake, register A_h, A_l, B_h, B_l (upper/lower DATA_W/2 halves) and go to P_HH.
REQ-020 SHALL, in P_HH, drive mul_a={0,A_h}, mul_b={0,B_h}, register m1=mul_p[DATA_W-1:0], and go to P_LL.
REQ-021 SHALL, in P_LL, drive mul_a={0,A_l}, mul_b={0,B_l}, register m2=mul_p[DATA_W-1:0], and go to P_MID.
REQ-022 SHALL, in P_MID, drive mul_a=A_h+A_l, mul_b=B_h+B_l (DATA_W/2+1 bits, carry kept), register mid=mul_p-m1-m2 in DATA_W+2 bits (never negative), and go to COMB.
REQ-023 SHALL, in COMB, register S=(m1<<DATA_W)+(mid<<(DATA_W/2))+m2, computed in 2*DATA_W+2 bits, truncated to 2*DATA_W (exact for all inputs), and go to DONE.
REQ-024 SHALL drive mul_a=mul_b=0 in IDLE, COMB, DONE.
REQ-025 SHALL assert out_valid only in DONE; S SHALL stay stable while out_valid=1 and out_ready=0.
REQ-026 SHALL, on out_valid&&out_ready, increment op_count (wrap at 2^CNT_W-1 to 0) and go to IDLE.
REQ-027 SHALL give fixed latency: handshake at edge k -> out_valid=1 from cycle after edge k+4; no input accepted in the DONE cycle of the output handshake (min 6 cycles per operation).
REQ-028 SHALL ignore in_valid and A/B changes in all non-IDLE states; registered operands unaffected.
REQ-029 SHALL treat any other state encoding as IDLE on the next edge.

Reset
REQ-030 SHALL, while rst=1 at a clock edge, set state=IDLE, out_valid=0, S=0, op_count=0, internal operand/partial registers=0; busy=0, in_ready=1 after that edge.
REQ-031 SHALL, on rst mid-operation (any state), abandon the operation without producing out_valid and without incrementing op_count.
REQ-032 SHALL give rst priority over simultaneous input or output handshakes.

Verification
REQ-033 Bench SHALL check: DATA_W=32, A=3, B=5, out_ready=1 -> S=0x000000000000000F, out_valid exactly 5 cycles after accept edge, op_count=1.
REQ-034 Bench SHALL check: A=B=0xFFFFFFFF -> S=0xFFFFFFFE00000001 (exercises 17-bit carry in P_MID).
REQ-035 Bench SHALL check: A=B=0x00010000, out_ready=0 for 10 cycles -> out_valid held, S=0x0000000100000000 stable, in_ready=0, op_count unchanged until release.
REQ-036 Bench SHALL check: rst pulsed in P_MID -> next cycle busy=0, out_valid=0, op_count=0, in_ready=1; following op A=7,B=9 -> S=63.
REQ-037 Bench SHALL check: 1000 back-to-back random operand pairs, in_valid held high -> each S equals A*B reference model, mul_a/mul_b sequence matches REQ-020..022, op_count=1000.
REQ-038 Bench SHALL check: in_valid toggling with changing A/B during P_HH..DONE -> result reflects only accepted pair.

Source files
------------

// File: rtl/karatsuba_sched.sv
// Karatsuba multiplication scheduler: forms a DATA_W x DATA_W product from three
// (DATA_W/2+1)-bit products on one external combinational multiplier.
module karatsuba_sched #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     A,
    input  logic [DATA_W-1:0]     B,
    output logic [DATA_W/2:0]     mul_a,
    output logic [DATA_W/2:0]     mul_b,
    input  logic [DATA_W+1:0]     mul_p,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [2*DATA_W-1:0]   S,
    output logic                  busy,
    output logic [CNT_W-1:0]      op_count
);

    localparam int HW = DATA_W / 2;
    localparam int SW = 2 * DATA_W + 2;

    // IDLE accept | P_HH hi*hi | P_LL lo*lo | P_MID sum*sum | COMB assemble | DONE present
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        P_HH  = 3'd1,
        P_LL  = 3'd2,
        P_MID = 3'd3,
        COMB  = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t              state_q, state_d;
    logic [HW-1:0]       ah_q, ah_d, al_q, al_d, bh_q, bh_d, bl_q, bl_d;
    logic [DATA_W-1:0]   m1_q, m1_d, m2_q, m2_d;
    logic [DATA_W+1:0]   mid_q, mid_d;
    logic [2*DATA_W-1:0] s_q, s_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [SW-1:0]       s_wide;

    assign s_wide = (SW'(m1_q) << DATA_W) + (SW'(mid_q) << HW) + SW'(m2_q);

    always_comb begin
        state_d   = state_q;
        ah_d      = ah_q;
        al_d      = al_q;
        bh_d      = bh_q;
        bl_d      = bl_q;
        m1_d      = m1_q;
        m2_d      = m2_q;
        mid_d     = mid_q;
        s_d       = s_q;
        cnt_d     = cnt_q;
        mul_a     = '0;
        mul_b     = '0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state_q)
            IDLE: begin
                busy     = 1'b0;
                in_ready = 1'b1;
                if (in_valid) begin
                    ah_d    = A[DATA_W-1:HW];
                    al_d    = A[HW-1:0];
                    bh_d    = B[DATA_W-1:HW];
                    bl_d    = B[HW-1:0];
                    state_d = P_HH;
                end
            end
            P_HH: begin
                mul_a   = {1'b0, ah_q};
                mul_b   = {1'b0, bh_q};
                m1_d    = mul_p[DATA_W-1:0];
                state_d = P_LL;
            end
            P_LL: begin
                mul_a   = {1'b0, al_q};
                mul_b   = {1'b0, bl_q};
                m2_d    = mul_p[DATA_W-1:0];
                state_d = P_MID;
            end
            P_MID: begin
                mul_a   = {1'b0, ah_q} + {1'b0, al_q};
                mul_b   = {1'b0, bh_q} + {1'b0, bl_q};
                mid_d   = mul_p - {2'b00, m1_q} - {2'b00, m2_q};
                state_d = COMB;
            end
            COMB: begin
                s_d     = s_wide[2*DATA_W-1:0];
                state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ah_q    <= '0;
            al_q    <= '0;
            bh_q    <= '0;
            bl_q    <= '0;
            m1_q    <= '0;
            m2_q    <= '0;
            mid_q   <= '0;
            s_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ah_q    <= ah_d;
            al_q    <= al_d;
            bh_q    <= bh_d;
            bl_q    <= bl_d;
            m1_q    <= m1_d;
            m2_q    <= m2_d;
            mid_q   <= mid_d;
            s_q     <= s_d;
            cnt_q   <= cnt_d;
        end
    end

    assign S        = s_q;
    assign op_count = cnt_q;

endmodule

// File: tb/tb_karatsuba_sched.sv
// Bench for karatsuba_sched: directed corner cases plus random back-to-back traffic,
// checked against plain 64-bit multiplication.
module tb_karatsuba_sched;
    localparam int DW = 32;
    localparam int CW = 16;
    localparam int HW = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [DW-1:0]   A, B;
    logic [HW:0]     mul_a, mul_b;
    logic [DW+1:0]   mul_p;
    logic            out_valid;
    logic            out_ready;
    logic [2*DW-1:0] S;
    logic            busy;
    logic [CW-1:0]   op_count;

    int errors = 0;
    int checks = 0;

    karatsuba_sched #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
        .out_valid(out_valid), .out_ready(out_ready), .S(S),
        .busy(busy), .op_count(op_count)
    );

    // External shared multiplier
    assign mul_p = mul_a * mul_b;

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Present one pair for a single accept edge; returns just after that edge.
    task automatic accept_pair(input logic [DW-1:0] a, input logic [DW-1:0] b);
        int w;
        w = 0;
        @(negedge clk);
        while (!in_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) begin
            errors++;
            $display("FAIL accept_timeout: in_ready=%0b required 1", in_ready);
        end
        checks++;
        A = a;
        B = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Counts cycles (1 = the cycle after the accept edge) until out_valid is seen.
    task automatic wait_out(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!out_valid && cyc < 30);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        A = '0;
        B = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({busy, in_ready, out_valid} !== 3'b010) begin
            errors++;
            $display("FAIL reset_flags: busy/in_ready/out_valid=%b required 010", {busy, in_ready, out_valid});
        end
        checks++;
        if (S !== '0 || op_count !== '0) begin
            errors++;
            $display("FAIL reset_regs: S=%h op_count=%0d required 0/0", S, op_count);
        end
        checks++;
        if (mul_a !== '0 || mul_b !== '0) begin
            errors++;
            $display("FAIL reset_mul: mul_a=%h mul_b=%h required 0", mul_a, mul_b);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int cyc;
        out_ready = 1'b1;
        accept_pair(32'd3, 32'd5);
        wait_out(cyc);
        checks++;
        if (cyc !== 5) begin
            errors++;
            $display("FAIL basic_latency: cycles=%0d required 5", cyc);
        end
        checks++;
        if (S !== 64'h000000000000000F) begin
            errors++;
            $display("FAIL basic_S: S=%h required 000000000000000f", S);
        end
        @(negedge clk);
        checks++;
        if (op_count !== 16'd1 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL basic_after: op_count=%0d out_valid=%b in_ready=%b required 1/0/1",
                     op_count, out_valid, in_ready);
        end
    endtask

    task automatic test_max();
        int cyc;
        out_ready = 1'b1;
        accept_pair(32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_out(cyc);
        checks++;
        if (out_valid !== 1'b1 || S !== 64'hFFFFFFFE00000001) begin
            errors++;
            $display("FAIL max_S: out_valid=%b S=%h required 1/fffffffe00000001", out_valid, S);
        end
        @(negedge clk);
        checks++;
        if (op_count !== 16'd2) begin
            errors++;
            $display("FAIL max_count: op_count=%0d required 2", op_count);
        end
    endtask

    task automatic test_stall();
        int cyc;
        out_ready = 1'b0;
        accept_pair(32'h00010000, 32'h00010000);
        wait_out(cyc);
        for (int i = 0; i < 10; i++) begin
            if (i > 0) @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || S !== 64'h0000000100000000 || op_count !== 16'd2) begin
                errors++;
                $display("FAIL stall_hold[%0d]: out_valid=%b in_ready=%b S=%h op_count=%0d required 1/0/0000000100000000/2",
                         i, out_valid, in_ready, S, op_count);
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (op_count !== 16'd3 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_release: op_count=%0d out_valid=%b required 3/0", op_count, out_valid);
        end
    endtask

    task automatic test_reset_mid();
        int cyc;
        out_ready = 1'b1;
        accept_pair(32'h00001234, 32'h00005678);
        repeat (3) @(negedge clk);
        checks++;
        if (mul_a !== 17'h01234 || mul_b !== 17'h05678) begin
            errors++;
            $display("FAIL rstmid_pmid_mul: mul_a=%h mul_b=%h required 01234/05678", mul_a, mul_b);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, out_valid, in_ready} !== 3'b001 || op_count !== '0) begin
            errors++;
            $display("FAIL rstmid_after: busy/out_valid/in_ready=%b op_count=%0d required 001/0",
                     {busy, out_valid, in_ready}, op_count);
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL rstmid_no_output[%0d]: out_valid=%b required 0", i, out_valid);
            end
        end
        accept_pair(32'd7, 32'd9);
        wait_out(cyc);
        checks++;
        if (out_valid !== 1'b1 || S !== 64'd63) begin
            errors++;
            $display("FAIL rstmid_next_S: out_valid=%b S=%0d required 1/63", out_valid, S);
        end
        @(negedge clk);
        checks++;
        if (op_count !== 16'd1) begin
            errors++;
            $display("FAIL rstmid_count: op_count=%0d required 1", op_count);
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0]   a, b;
        logic [HW-1:0]   ah, al, bh, bl;
        logic [HW:0]     ea, eb;
        logic [2*DW-1:0] ref_s;
        int              done_ops;
        int              w;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        in_valid = 1'b1;
        done_ops = 0;
        for (int n = 0; n < 1000; n++) begin
            a = $urandom;
            b = $urandom;
            if (n == 0) begin a = 32'hFFFF0001; b = 32'h0001FFFF; end
            ah = a[DW-1:HW]; al = a[HW-1:0];
            bh = b[DW-1:HW]; bl = b[HW-1:0];
            ref_s = 64'(a) * 64'(b);
            w = 0;
            @(negedge clk);
            while (!in_ready && w < 20) begin
                @(negedge clk);
                w++;
            end
            if (!in_ready) begin
                checks++;
                errors++;
                $display("FAIL b2b_ready_timeout[%0d]: in_ready=%b required 1", n, in_ready);
                break;
            end
            A = a;
            B = b;
            for (int c = 1; c <= 5; c++) begin
                @(negedge clk);
                case (c)
                    1: begin ea = {1'b0, ah}; eb = {1'b0, bh}; end
                    2: begin ea = {1'b0, al}; eb = {1'b0, bl}; end
                    3: begin ea = 17'(ah) + 17'(al); eb = 17'(bh) + 17'(bl); end
                    default: begin ea = '0; eb = '0; end
                endcase
                if (c < 5) begin
                    checks++;
                    if (mul_a !== ea || mul_b !== eb || out_valid !== 1'b0) begin
                        errors++;
                        $display("FAIL b2b_mul[%0d.%0d]: mul_a=%h mul_b=%h out_valid=%b required %h/%h/0",
                                 n, c, mul_a, mul_b, out_valid, ea, eb);
                    end
                end else begin
                    checks++;
                    if (out_valid !== 1'b1 || S !== ref_s) begin
                        errors++;
                        $display("FAIL b2b_S[%0d]: A=%h B=%h out_valid=%b S=%h required 1/%h",
                                 n, a, b, out_valid, S, ref_s);
                    end else begin
                        done_ops++;
                    end
                end
            end
        end
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (op_count !== 16'd1000 || done_ops != 1000) begin
            errors++;
            $display("FAIL b2b_count: op_count=%0d good_ops=%0d required 1000", op_count, done_ops);
        end
    endtask

    task automatic test_ignore_inputs();
        logic [DW-1:0]   a0, b0;
        logic [2*DW-1:0] ref_s;
        logic [CW-1:0]   cnt0;
        int              cyc;
        out_ready = 1'b1;
        a0 = $urandom;
        b0 = $urandom;
        ref_s = 64'(a0) * 64'(b0);
        cnt0 = op_count;
        accept_pair(a0, b0);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (!out_valid) begin
                in_valid = cyc[0];
                A = $urandom;
                B = $urandom;
            end
        end while (!out_valid && cyc < 30);
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || S !== ref_s) begin
            errors++;
            $display("FAIL ignore_S: out_valid=%b S=%h required 1/%h", out_valid, S, ref_s);
        end
        @(negedge clk);
        checks++;
        if (op_count !== cnt0 + CW'(1) || busy !== 1'b0) begin
            errors++;
            $display("FAIL ignore_after: op_count=%0d busy=%b required %0d/0", op_count, busy, cnt0 + CW'(1));
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_max();
        test_stall();
        test_reset_mid();
        test_back_to_back();
        test_ignore_inputs();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
